data_stack: RTL and testbench

//  Operand stack for the brus16 core; sits directly upstream of alu.

---
 rtl/data_stack_pkg.sv | 26 ++
 rtl/data_stack_ram.sv | 30 +++
 rtl/data_stack.sv | 153 +++++++++++++++
 tb/tb_data_stack.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/data_stack_pkg.sv
// Shared definitions for the operand stack: op encodings and helpers.
package data_stack_pkg;

    // Stack operation encodings; 6 and 7 are reserved and behave as NOP.
    typedef enum logic [2:0] {
        STK_NOP  = 3'd0,
        STK_PUSH = 3'd1,
        STK_POP  = 3'd2,
        STK_POP2 = 3'd3,
        STK_REP1 = 3'd4,
        STK_REP2 = 3'd5
    } stk_op_e;

    localparam int STK_WIDTH_DEF = 16;
    localparam int STK_DEPTH_DEF = 32;

    // Minimum number of valid entries an op needs before it may proceed.
    function automatic int unsigned op_min_depth(input stk_op_e op);
        case (op)
            STK_POP, STK_REP1:  op_min_depth = 1;
            STK_POP2, STK_REP2: op_min_depth = 2;
            default:            op_min_depth = 0;
        endcase
    endfunction

endpackage

// File: rtl/data_stack_ram.sv
// Stack storage: one synchronous write port, two asynchronous read ports
// (top-of-stack and next-on-stack addresses supplied by the pointer logic).
module data_stack_ram #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr0_i,
    input  logic [AW-1:0]    raddr1_i,
    output logic [WIDTH-1:0] rdata0_o,
    output logic [WIDTH-1:0] rdata1_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Single write port; contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata0_o = mem_q[raddr0_i];
    assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/data_stack.sv
// Operand stack feeding the ALU: tos/nos presented combinationally from
// registered state, one op committed per clock, sticky overflow/underflow.
module data_stack
    import data_stack_pkg::*;
#(
    parameter int WIDTH = STK_WIDTH_DEF,
    parameter int DEPTH = STK_DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [2:0]               op,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         tos,
    output logic [WIDTH-1:0]         nos,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;
    localparam logic [DW-1:0] DEPTH_W = DW'(DEPTH);
    localparam logic [DW-1:0] ONE_W   = DW'(1);
    localparam logic [DW-1:0] TWO_W   = DW'(2);
    localparam logic [AW-1:0] ONE_A   = AW'(1);
    localparam logic [AW-1:0] TWO_A   = AW'(2);

    logic [DW-1:0]    depth_q, depth_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    stk_op_e          op_e;
    logic             has1, has2, has_room, legal;
    logic [AW-1:0]    tos_addr, nos_addr;
    logic             ram_we;
    logic [AW-1:0]    ram_waddr;
    logic [WIDTH-1:0] ram_rd0, ram_rd1;

    assign op_e = stk_op_e'(op);

    // Entry addresses come from the low pointer bits only; when they are
    // not meaningful (depth < 1 or < 2) the read value is masked below.
    assign tos_addr = depth_q[AW-1:0] - ONE_A;
    assign nos_addr = depth_q[AW-1:0] - TWO_A;

    // Occupancy tests and legality of the requested op.
    always_comb begin
        has1     = (depth_q != '0);
        has2     = (depth_q >= TWO_W);
        has_room = (depth_q != DEPTH_W);
        legal    = 1'b1;
        case (op_min_depth(op_e))
            1:       legal = has1;
            2:       legal = has2;
            default: legal = 1'b1;
        endcase
        if (op_e == STK_PUSH) begin
            legal = has_room;
        end
    end

    // Next pointer, flag and write-port control; illegal ops only raise a flag.
    always_comb begin
        depth_d   = depth_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        ram_we    = 1'b0;
        ram_waddr = depth_q[AW-1:0];
        case (op_e)
            STK_PUSH: begin
                if (legal) begin
                    ram_we    = 1'b1;
                    ram_waddr = depth_q[AW-1:0];
                    depth_d   = depth_q + ONE_W;
                end else begin
                    ovf_d = 1'b1;
                end
            end
            STK_POP: begin
                if (legal) begin
                    depth_d = depth_q - ONE_W;
                end else begin
                    unf_d = 1'b1;
                end
            end
            STK_POP2: begin
                if (legal) begin
                    depth_d = depth_q - TWO_W;
                end else begin
                    unf_d = 1'b1;
                end
            end
            STK_REP1: begin
                if (legal) begin
                    ram_we    = 1'b1;
                    ram_waddr = tos_addr;
                end else begin
                    unf_d = 1'b1;
                end
            end
            STK_REP2: begin
                if (legal) begin
                    ram_we    = 1'b1;
                    ram_waddr = nos_addr;
                    depth_d   = depth_q - ONE_W;
                end else begin
                    unf_d = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Pointer and sticky flags; reset discards all entries.
    always_ff @(posedge clk) begin
        if (reset) begin
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    data_stack_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i    (clk),
        .we_i     (ram_we && !reset),
        .waddr_i  (ram_waddr),
        .wdata_i  (wdata),
        .raddr0_i (tos_addr),
        .raddr1_i (nos_addr),
        .rdata0_o (ram_rd0),
        .rdata1_o (ram_rd1)
    );

    assign tos       = has1 ? ram_rd0 : '0;
    assign nos       = has2 ? ram_rd1 : '0;
    assign depth     = depth_q;
    assign empty     = !has1;
    assign full      = !has_room;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_data_stack.sv
module tb_data_stack;
    import data_stack_pkg::*;

    localparam int W  = 16;
    localparam int D  = 32;
    localparam int DW = $clog2(D) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [2:0]    op = 3'd0;
    logic [W-1:0]  wdata = '0;
    logic [W-1:0]  tos, nos;
    logic [DW-1:0] depth;
    logic          empty, full, overflow, underflow;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [W-1:0] tos;
        logic [W-1:0] nos;
        int           depth;
        bit           ovf;
        bit           unf;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] mdl[$];
    bit           m_ovf = 1'b0;
    bit           m_unf = 1'b0;

    data_stack #(.WIDTH(W), .DEPTH(D)) dut (
        .clk       (clk),
        .reset     (reset),
        .op        (op),
        .wdata     (wdata),
        .tos       (tos),
        .nos       (nos),
        .depth     (depth),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Reference model of one clock of the stack.
    task automatic model_apply(input logic [2:0] o, input logic [W-1:0] w, input bit r);
        int n;
        n = mdl.size();
        if (r) begin
            mdl.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            case (o)
                3'd1: if (n < D) mdl.push_back(w); else m_ovf = 1'b1;
                3'd2: if (n >= 1) void'(mdl.pop_back()); else m_unf = 1'b1;
                3'd3: if (n >= 2) begin void'(mdl.pop_back()); void'(mdl.pop_back()); end
                      else m_unf = 1'b1;
                3'd4: if (n >= 1) mdl[n-1] = w; else m_unf = 1'b1;
                3'd5: if (n >= 2) begin void'(mdl.pop_back()); mdl[n-2] = w; end
                      else m_unf = 1'b1;
                default: ;
            endcase
        end
    endtask

    task automatic step(input logic [2:0] o, input logic [W-1:0] w, input bit r);
        exp_t e;
        int   n;
        @(negedge clk);
        op    = o;
        wdata = w;
        reset = r;
        model_apply(o, w, r);
        n       = mdl.size();
        e.tos   = (n >= 1) ? mdl[n-1] : '0;
        e.nos   = (n >= 2) ? mdl[n-2] : '0;
        e.depth = n;
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        reset = 1'b0;
        op    = 3'd0;
        if (exp_q.size() == 0) begin
            check("scoreboard_underrun", 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check("tos",       32'(tos),       32'(e.tos));
            check("nos",       32'(nos),       32'(e.nos));
            check("depth",     32'(depth),     32'(e.depth));
            check("empty",     32'(empty),     32'(e.depth == 0));
            check("full",      32'(full),      32'(e.depth == D));
            check("overflow",  32'(overflow),  32'(e.ovf));
            check("underflow", 32'(underflow), 32'(e.unf));
        end
    endtask

    initial begin
        int r;
        logic [2:0] o;

        // Reset state
        step(3'(STK_NOP), '0, 1'b1);
        check("rst_depth", 32'(depth), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full",  32'(full),  32'd0);

        // 1: 5 - 3 via REP2
        step(3'(STK_PUSH), 16'd5, 1'b0);
        step(3'(STK_PUSH), 16'd3, 1'b0);
        step(3'(STK_REP2), 16'd2, 1'b0);
        check("t1_tos",   32'(tos),   32'd2);
        check("t1_nos",   32'(nos),   32'd0);
        check("t1_depth", 32'(depth), 32'd1);

        // 2: REP1 rewrites top only
        step(3'(STK_NOP), '0, 1'b1);
        step(3'(STK_PUSH), 16'h00FF, 1'b0);
        step(3'(STK_REP1), 16'hABFF, 1'b0);
        check("t2_tos",   32'(tos),   32'hABFF);
        check("t2_depth", 32'(depth), 32'd1);

        // 3: fill, overflow, pop
        step(3'(STK_NOP), '0, 1'b1);
        for (int i = 1; i <= D; i++) step(3'(STK_PUSH), W'(i), 1'b0);
        check("t3_full", 32'(full), 32'd1);
        check("t3_tos",  32'(tos),  32'd32);
        check("t3_nos",  32'(nos),  32'd31);
        step(3'(STK_PUSH), 16'd99, 1'b0);
        check("t3_ovf",   32'(overflow), 32'd1);
        check("t3_depth", 32'(depth),    32'd32);
        check("t3_tos2",  32'(tos),      32'd32);
        step(3'(STK_POP), '0, 1'b0);
        check("t3_tos3",  32'(tos),      32'd31);
        check("t3_ovf2",  32'(overflow), 32'd1);

        // 4: underflow cases
        step(3'(STK_NOP), '0, 1'b1);
        step(3'(STK_POP), '0, 1'b0);
        check("t4_unf",   32'(underflow), 32'd1);
        check("t4_depth", 32'(depth),     32'd0);
        step(3'(STK_NOP), '0, 1'b1);
        step(3'(STK_PUSH), 16'd11, 1'b0);
        step(3'(STK_POP2), '0, 1'b0);
        check("t4_pop2_depth", 32'(depth),     32'd1);
        check("t4_pop2_tos",   32'(tos),       32'd11);
        check("t4_pop2_unf",   32'(underflow), 32'd1);
        step(3'(STK_NOP), '0, 1'b1);
        step(3'(STK_PUSH), 16'd12, 1'b0);
        step(3'(STK_REP2), 16'd77, 1'b0);
        check("t4_rep2_depth", 32'(depth),     32'd1);
        check("t4_rep2_tos",   32'(tos),       32'd12);
        check("t4_rep2_unf",   32'(underflow), 32'd1);

        // 5: POP2 to empty, reset beats PUSH
        step(3'(STK_NOP), '0, 1'b1);
        step(3'(STK_PUSH), 16'd7, 1'b0);
        step(3'(STK_PUSH), 16'd8, 1'b0);
        step(3'(STK_POP2), '0, 1'b0);
        check("t5_empty", 32'(empty), 32'd1);
        check("t5_tos",   32'(tos),   32'd0);
        step(3'(STK_POP), '0, 1'b0);
        step(3'(STK_PUSH), 16'd5, 1'b1);
        check("t5_rst_depth", 32'(depth),     32'd0);
        check("t5_rst_unf",   32'(underflow), 32'd0);

        // 6: random stream with alternating push-heavy / pop-heavy phases
        step(3'(STK_NOP), '0, 1'b1);
        for (int i = 0; i < 1200; i++) begin
            r = int'($urandom_range(0, 9));
            if (((i / 150) % 2) == 0) o = (r < 6) ? 3'(STK_PUSH) : 3'($urandom_range(0, 7));
            else                      o = (r < 4) ? 3'(STK_PUSH) : 3'($urandom_range(0, 7));
            step(o, W'($urandom), ($urandom_range(0, 299) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
